l2_snoop_responder: RTL and testbench
=====================================

// Module: l2_snoop_responder
// PURPOSE
//  Bus-side responder for snoops observed from other caches against the L2.
//  Accepts one snooped bus op, looks up the tag/MESI array and drives a snoop result (HIT/HITM/NOHIT).
//  Applies the MESI downgrade or invalidate, and pushes dirty (M) lines to the write-back path before responding.
//  Sits between the bus snoop monitor and the L2 tag/MESI array, beside the eviction/LRU logic.
// PARAMETERS
//  ADDR_W    32  snooped physical address width
//  INDEX_W   14  set index width (matches index_size)
//  OFFSET_W  6   line offset width (matches offset_size)
//  WAY_W     3   way select width, 8 ways
//  TAG_W     = ADDR_W-INDEX_W-OFFSET_W, derived localparam; not overridable
// PORTS
//  clk        in   1         clock, all logic rising-edge
//  rst        in   1         synchronous, active-high reset
//  snp_valid  in   1         snooped bus op present
//  snp_ready  out  1         responder idle, can accept
//  snp_op     in   3         1=READ 2=WRITE 3=INVALIDATE 4=RWIM; others reserved
//  snp_addr   in   ADDR_W    snooped address
//  tl_req     out  1         tag lookup request, one-cycle pulse
//  tl_index   out  INDEX_W   lookup set
//  tl_tag     out  TAG_W     lookup tag
//  tl_hit     in   1         valid cycle after tl_req: tag match on non-I way
//  tl_way     in   WAY_W     matching way
//  tl_mesi    in   2         matching way state, M=00 E=01 S=10 I=11
//  mu_we      out  1         MESI write strobe, one cycle
//  mu_index   out  INDEX_W   MESI write set
//  mu_way     out  WAY_W     MESI write way
//  mu_mesi    out  2         new state
//  wb_valid   out  1         dirty line write-back request
//  wb_ready   in   1         write-back path accepts
//  wb_addr    out  ADDR_W    {tag,index,OFFSET_W'b0}
//  res_valid  out  1         snoop result strobe, one cycle
//  res_code   out  2         00=HIT 01=HITM 10=NOHIT
//  err        out  1         one-cycle pulse, protocol violation or reserved op
// BEHAVIOUR
//  Reset: state IDLE; snp_ready=1; tl_req, mu_we, wb_valid, res_valid and err=0; data outputs 0.
//  Reset mid-operation aborts the op: no mu_we, no res_valid, wb_valid drops.
//  FSM: IDLE -> LOOKUP -> WAIT -> [WB] -> RESP -> IDLE.
//   IDLE: snp_ready=1; on snp_valid&snp_ready, register op and addr -> LOOKUP.
//         snp_ready=0 in all other states.
//   LOOKUP: tl_req=1, tl_index/tl_tag from the registered addr -> WAIT.
//   WAIT: register tl_hit/way/mesi.
//         -> WB if hit & M & (READ|RWIM); else -> RESP.
//   WB: wb_valid held high, wb_addr stable until wb_valid&wb_ready -> RESP.
//   RESP: res_valid=1; mu_we=1 only if the state changes -> IDLE.
//  Result: miss or I -> NOHIT; E/S -> HIT; M -> HITM. WRITE always reports NOHIT.
//  Next state (hit only):
//   READ:  E->S, S->S, M->S after write-back.
//   RWIM:  any->I; M->I only after write-back.
//   INVALIDATE: S->I; E/M unchanged, err=1 in RESP.
//   WRITE: no change.
//  Reserved op: NOHIT, no update, err=1 in RESP.
//  Latency: accept at T -> res_valid at T+3. With WB: wb_valid at T+3, res_valid the cycle after the handshake.
//  One op in flight; no pipelining. tl_* inputs are sampled only in WAIT.
// STRUCTURE
//  Shared include l2_defs.vh holds:
//   MESI encodings, bus op codes, snoop result codes, index/tag/offset widths.
//  Sub-module l2_snoop_next_state: combinational (op,hit,mesi) -> (res_code,new_mesi,need_wb,upd,err).
//  Top: FSM plus registers.
// TESTING
//  1. READ, hit way 5 in E, idx 0x0001: res_valid at T+3 with HIT; mu_we way 5 -> S; no wb_valid.
//  2. RWIM, addr tag 0x111 idx 0, way 2 in M, wb_ready low 4 cycles:
//     wb_valid held, wb_addr {0x111,0,0}; res HITM a cycle after the handshake; way 2 -> I.
//  3. READ, miss: NOHIT at T+3; mu_we never asserted.
//  4. INVALIDATE, hit in S -> I, HIT.
//     Then INVALIDATE, hit in M: err pulse, no mu_we.
//  5. rst pulsed while in WB: next cycle IDLE, snp_ready=1, wb_valid=0, no res_valid.
//  6. Back-to-back snp_valid: second op accepted only after RESP; snp_ready=0 throughout the first op.

Source files
------------

// File: rtl/l2_snoop_responder_pkg.sv
// Shared MESI, bus-op and snoop-result encodings plus default L2 geometry.
// Pure declarations: no latency or flow-control behaviour.
package l2_snoop_responder_pkg;

    localparam int L2_ADDR_W   = 32;
    localparam int L2_INDEX_W  = 14;
    localparam int L2_OFFSET_W = 6;
    localparam int L2_WAY_W    = 3;

    localparam logic [1:0] MESI_M = 2'b00;
    localparam logic [1:0] MESI_E = 2'b01;
    localparam logic [1:0] MESI_S = 2'b10;
    localparam logic [1:0] MESI_I = 2'b11;

    localparam logic [2:0] OP_READ       = 3'd1;
    localparam logic [2:0] OP_WRITE      = 3'd2;
    localparam logic [2:0] OP_INVALIDATE = 3'd3;
    localparam logic [2:0] OP_RWIM       = 3'd4;

    localparam logic [1:0] RES_HIT   = 2'b00;
    localparam logic [1:0] RES_HITM  = 2'b01;
    localparam logic [1:0] RES_NOHIT = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_WAIT   = 3'd2,
        ST_WB     = 3'd3,
        ST_RESP   = 3'd4
    } snp_state_t;

endpackage

// File: rtl/l2_snoop_responder_next_state.sv
// Combinational snoop decision: (op, hit, mesi) -> result, new MESI state, write-back need.
// Zero latency; no flow control.
module l2_snoop_responder_next_state
    import l2_snoop_responder_pkg::*;
(
    input  logic [2:0] op,
    input  logic       hit,
    input  logic [1:0] mesi,
    output logic [1:0] res_code,
    output logic [1:0] new_mesi,
    output logic       need_wb,
    output logic       upd,
    output logic       err
);

    logic present;
    logic [1:0] hit_code;

    always_comb begin
        present  = hit && (mesi != MESI_I);
        hit_code = (mesi == MESI_M) ? RES_HITM : RES_HIT;
        res_code = RES_NOHIT;
        new_mesi = mesi;
        need_wb  = 1'b0;
        upd      = 1'b0;
        err      = 1'b0;
        case (op)
            OP_READ: if (present) begin
                res_code = hit_code;
                new_mesi = MESI_S;
                need_wb  = (mesi == MESI_M);
                upd      = (mesi != MESI_S);
            end
            OP_RWIM: if (present) begin
                res_code = hit_code;
                new_mesi = MESI_I;
                need_wb  = (mesi == MESI_M);
                upd      = 1'b1;
            end
            OP_INVALIDATE: if (present) begin
                res_code = hit_code;
                // An invalidate against an owned (E/M) line is illegal: flag it, keep the line.
                if (mesi == MESI_S) begin
                    new_mesi = MESI_I;
                    upd      = 1'b1;
                end else begin
                    err = 1'b1;
                end
            end
            OP_WRITE: ;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/l2_snoop_responder.sv
// Snoop responder FSM: lookup, optional dirty write-back, MESI update and result; result 3 cycles after accept.
// One op in flight; snp_ready low while busy, wb_valid held until wb_ready.
module l2_snoop_responder
    import l2_snoop_responder_pkg::*;
#(
    parameter int ADDR_W   = L2_ADDR_W,
    parameter int INDEX_W  = L2_INDEX_W,
    parameter int OFFSET_W = L2_OFFSET_W,
    parameter int WAY_W    = L2_WAY_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          snp_valid,
    output logic                          snp_ready,
    input  logic [2:0]                    snp_op,
    input  logic [ADDR_W-1:0]             snp_addr,
    output logic                          tl_req,
    output logic [INDEX_W-1:0]            tl_index,
    output logic [ADDR_W-INDEX_W-OFFSET_W-1:0] tl_tag,
    input  logic                          tl_hit,
    input  logic [WAY_W-1:0]              tl_way,
    input  logic [1:0]                    tl_mesi,
    output logic                          mu_we,
    output logic [INDEX_W-1:0]            mu_index,
    output logic [WAY_W-1:0]              mu_way,
    output logic [1:0]                    mu_mesi,
    output logic                          wb_valid,
    input  logic                          wb_ready,
    output logic [ADDR_W-1:0]             wb_addr,
    output logic                          res_valid,
    output logic [1:0]                    res_code,
    output logic                          err
);

    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    snp_state_t             state, state_nx;
    logic [2:0]             op_q;
    logic [ADDR_W-1:0]      addr_q;
    logic                   hit_q;
    logic [WAY_W-1:0]       way_q;
    logic [1:0]             mesi_q;

    logic [1:0]             ns_code;
    logic [1:0]             ns_mesi;
    logic                   ns_wb;
    logic                   ns_upd;
    logic                   ns_err;

    logic [INDEX_W-1:0]     index_q;
    logic [TAG_W-1:0]       tag_q;

    assign index_q = addr_q[OFFSET_W +: INDEX_W];
    assign tag_q   = addr_q[ADDR_W-1 -: TAG_W];

    l2_snoop_responder_next_state u_next_state (
        .op       (op_q),
        .hit      (hit_q),
        .mesi     (mesi_q),
        .res_code (ns_code),
        .new_mesi (ns_mesi),
        .need_wb  (ns_wb),
        .upd      (ns_upd),
        .err      (ns_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            op_q   <= '0;
            addr_q <= '0;
            hit_q  <= 1'b0;
            way_q  <= '0;
            mesi_q <= MESI_I;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && snp_valid) begin
                op_q   <= snp_op;
                addr_q <= snp_addr;
            end
            if (state == ST_WAIT) begin
                hit_q  <= tl_hit;
                way_q  <= tl_way;
                mesi_q <= tl_mesi;
            end
        end
    end

    // WB decision uses the live tl_* inputs, since the registered copies land on the same edge.
    logic wait_wb;
    always_comb begin
        wait_wb = tl_hit && (tl_mesi == MESI_M) && ((op_q == OP_READ) || (op_q == OP_RWIM));
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (snp_valid) state_nx = ST_LOOKUP;
            ST_LOOKUP: state_nx = ST_WAIT;
            ST_WAIT:   state_nx = wait_wb ? ST_WB : ST_RESP;
            ST_WB:     if (wb_ready) state_nx = ST_RESP;
            ST_RESP:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        snp_ready = (state == ST_IDLE);
        tl_req    = (state == ST_LOOKUP);
        wb_valid  = (state == ST_WB) && ns_wb;
        res_valid = (state == ST_RESP);
        mu_we     = (state == ST_RESP) && ns_upd;
        err       = (state == ST_RESP) && ns_err;
        tl_index  = tl_req ? index_q : '0;
        tl_tag    = tl_req ? tag_q : '0;
        wb_addr   = wb_valid ? {tag_q, index_q, {OFFSET_W{1'b0}}} : '0;
        mu_index  = mu_we ? index_q : '0;
        mu_way    = mu_we ? way_q : '0;
        mu_mesi   = mu_we ? ns_mesi : 2'b00;
        res_code  = res_valid ? ns_code : 2'b00;
    end

endmodule

// File: tb/tb_l2_snoop_responder.sv
// Directed bench for l2_snoop_responder: bench plays the tag array and write-back path.
module tb_l2_snoop_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        snp_valid;
    logic        snp_ready;
    logic [2:0]  snp_op;
    logic [31:0] snp_addr;
    logic        tl_req;
    logic [13:0] tl_index;
    logic [11:0] tl_tag;
    logic        tl_hit;
    logic [2:0]  tl_way;
    logic [1:0]  tl_mesi;
    logic        mu_we;
    logic [13:0] mu_index;
    logic [2:0]  mu_way;
    logic [1:0]  mu_mesi;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_addr;
    logic        res_valid;
    logic [1:0]  res_code;
    logic        err;

    always #5 clk = ~clk;

    l2_snoop_responder dut (
        .clk(clk), .rst(rst),
        .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op), .snp_addr(snp_addr),
        .tl_req(tl_req), .tl_index(tl_index), .tl_tag(tl_tag),
        .tl_hit(tl_hit), .tl_way(tl_way), .tl_mesi(tl_mesi),
        .mu_we(mu_we), .mu_index(mu_index), .mu_way(mu_way), .mu_mesi(mu_mesi),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
        .res_valid(res_valid), .res_code(res_code), .err(err)
    );

    int nvec = 0;
    int nerr = 0;

    int          res_k, res_cnt, mu_cnt, err_cnt, wb_cnt, wb_first_k, rdy_cnt, treq_k;
    logic [1:0]  res_code_s, mu_mesi_s;
    logic [2:0]  mu_way_s;
    logic [13:0] mu_index_s, tl_index_s;
    logic [11:0] tl_tag_s;
    logic [31:0] wb_addr_s;
    logic        wb_unstable;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents one op and returns just after the accepting edge.
    task automatic start_op(input logic [2:0] op, input logic [31:0] addr,
                            input logic hit, input logic [2:0] way, input logic [1:0] mesi);
        snp_op    = op;
        snp_addr  = addr;
        tl_hit    = hit;
        tl_way    = way;
        tl_mesi   = mesi;
        wb_ready  = 1'b0;
        snp_valid = 1'b1;
        @(negedge clk);
        chk("acc_rdy", {31'd0, snp_ready}, 32'd1);
        @(posedge clk);
        #1 snp_valid = 1'b0;
    endtask

    // Samples one negedge per cycle (k=1 is the cycle after acceptance) until the result strobe.
    task automatic monitor_op(input int wb_lat, input int ncyc);
        res_k = -1; res_cnt = 0; mu_cnt = 0; err_cnt = 0; wb_cnt = 0; wb_first_k = -1;
        rdy_cnt = 0; treq_k = -1; wb_unstable = 1'b0;
        res_code_s = 2'b11; mu_mesi_s = 2'b00; mu_way_s = '0; mu_index_s = '0;
        tl_index_s = '0; tl_tag_s = '0; wb_addr_s = '0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (snp_ready) rdy_cnt++;
            if (tl_req && treq_k < 0) begin
                treq_k = k; tl_index_s = tl_index; tl_tag_s = tl_tag;
            end
            if (wb_valid) begin
                if (wb_cnt == 0) begin
                    wb_first_k = k; wb_addr_s = wb_addr;
                end else if (wb_addr !== wb_addr_s) begin
                    wb_unstable = 1'b1;
                end
                wb_cnt++;
                wb_ready = (wb_cnt > wb_lat);
            end
            if (mu_we) begin
                mu_cnt++; mu_way_s = mu_way; mu_mesi_s = mu_mesi; mu_index_s = mu_index;
            end
            if (err) err_cnt++;
            if (res_valid) begin
                res_cnt++; res_k = k; res_code_s = res_code;
                break;
            end
        end
        wb_ready = 1'b0;
        if (res_k < 0) $display("FAIL res_timeout: got no result within %0d cycles", ncyc);
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; snp_valid = 1'b0; snp_op = '0; snp_addr = '0;
        tl_hit = 1'b0; tl_way = '0; tl_mesi = 2'b11; wb_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready",  {31'd0, snp_ready}, 32'd1);
        chk("rst_strobes", {27'd0, tl_req, mu_we, wb_valid, res_valid, err}, 32'd0);
        chk("rst_data",   wb_addr | {18'd0, tl_index} | {18'd0, mu_index}, 32'd0);
        chk("rst_code",   {30'd0, res_code}, 32'd0);
        next_edge();
        rst = 1'b0;

        // READ hit way 5 in E, index 1 -> HIT, E->S, no write-back
        start_op(3'd1, 32'hABC0_0040, 1'b1, 3'd5, 2'b01);
        monitor_op(0, 20);
        chk("t1_treq_k",  treq_k, 32'd1);
        chk("t1_tl_idx",  {18'd0, tl_index_s}, 32'h1);
        chk("t1_tl_tag",  {20'd0, tl_tag_s}, 32'hABC);
        chk("t1_res_k",   res_k, 32'd3);
        chk("t1_code",    {30'd0, res_code_s}, 32'd0);
        chk("t1_mu_cnt",  mu_cnt, 32'd1);
        chk("t1_mu_way",  {29'd0, mu_way_s}, 32'd5);
        chk("t1_mu_mesi", {30'd0, mu_mesi_s}, 32'd2);
        chk("t1_mu_idx",  {18'd0, mu_index_s}, 32'h1);
        chk("t1_wb_cnt",  wb_cnt, 32'd0);
        chk("t1_busy",    rdy_cnt, 32'd0);
        next_edge();

        // RWIM hit way 2 in M, write-back path stalls 4 cycles
        start_op(3'd4, 32'h1110_0000, 1'b1, 3'd2, 2'b00);
        monitor_op(4, 30);
        chk("t2_wb_first", wb_first_k, 32'd3);
        chk("t2_wb_cnt",   wb_cnt, 32'd5);
        chk("t2_wb_addr",  wb_addr_s, 32'h1110_0000);
        chk("t2_wb_stab",  {31'd0, wb_unstable}, 32'd0);
        chk("t2_res_k",    res_k, 32'd8);
        chk("t2_code",     {30'd0, res_code_s}, 32'd1);
        chk("t2_mu_way",   {29'd0, mu_way_s}, 32'd2);
        chk("t2_mu_mesi",  {30'd0, mu_mesi_s}, 32'd3);
        next_edge();

        // READ miss
        start_op(3'd1, 32'h0000_1240, 1'b0, 3'd0, 2'b11);
        monitor_op(0, 20);
        chk("t3_res_k",  res_k, 32'd3);
        chk("t3_code",   {30'd0, res_code_s}, 32'd2);
        chk("t3_mu_cnt", mu_cnt, 32'd0);
        chk("t3_wb_cnt", wb_cnt, 32'd0);
        next_edge();

        // INVALIDATE hit in S -> I
        start_op(3'd3, 32'h0050_0080, 1'b1, 3'd1, 2'b10);
        monitor_op(0, 20);
        chk("t4a_code",    {30'd0, res_code_s}, 32'd0);
        chk("t4a_mu_mesi", {30'd0, mu_mesi_s}, 32'd3);
        chk("t4a_mu_cnt",  mu_cnt, 32'd1);
        chk("t4a_err",     err_cnt, 32'd0);
        next_edge();

        // INVALIDATE hit in M -> error, no update
        start_op(3'd3, 32'h0050_0080, 1'b1, 3'd1, 2'b00);
        monitor_op(0, 20);
        chk("t4b_err",    err_cnt, 32'd1);
        chk("t4b_mu_cnt", mu_cnt, 32'd0);
        chk("t4b_code",   {30'd0, res_code_s}, 32'd1);
        chk("t4b_wb_cnt", wb_cnt, 32'd0);
        next_edge();

        // Reserved op 5 with a hit: NOHIT and error
        start_op(3'd5, 32'h0050_0080, 1'b1, 3'd1, 2'b01);
        monitor_op(0, 20);
        chk("rsv_code",   {30'd0, res_code_s}, 32'd2);
        chk("rsv_err",    err_cnt, 32'd1);
        chk("rsv_mu_cnt", mu_cnt, 32'd0);
        next_edge();

        // READ hit in S: already shared, no MESI write
        start_op(3'd1, 32'h0000_0100, 1'b1, 3'd6, 2'b10);
        monitor_op(0, 20);
        chk("rds_code",   {30'd0, res_code_s}, 32'd0);
        chk("rds_mu_cnt", mu_cnt, 32'd0);
        next_edge();

        // READ hit in M, write-back accepted immediately -> HITM, M->S
        start_op(3'd1, 32'hFFF0_0FC0, 1'b1, 3'd7, 2'b00);
        monitor_op(0, 20);
        chk("rdm_wb_addr", wb_addr_s, 32'hFFF0_0FC0);
        chk("rdm_res_k",   res_k, 32'd4);
        chk("rdm_code",    {30'd0, res_code_s}, 32'd1);
        chk("rdm_mu_mesi", {30'd0, mu_mesi_s}, 32'd2);
        next_edge();

        // Reset while parked in WB aborts the op
        start_op(3'd4, 32'h2220_0080, 1'b1, 3'd3, 2'b00);
        for (int k = 1; k <= 4; k++) @(negedge clk);
        chk("t5_in_wb", {31'd0, wb_valid}, 32'd1);
        rst = 1'b1;
        next_edge();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_ready", {31'd0, snp_ready}, 32'd1);
        chk("t5_wb",    {31'd0, wb_valid}, 32'd0);
        begin
            int late;
            late = 0;
            for (int k = 0; k < 5; k++) begin
                if (res_valid || mu_we) late++;
                @(negedge clk);
            end
            chk("t5_no_resp", late, 32'd0);
        end
        next_edge();

        // Back-to-back: snp_valid held, second op waits for the first to respond
        snp_op = 3'd1; snp_addr = 32'hABC0_0040;
        tl_hit = 1'b1; tl_way = 3'd5; tl_mesi = 2'b01; wb_ready = 1'b0;
        snp_valid = 1'b1;
        @(negedge clk);
        chk("t6_acc1", {31'd0, snp_ready}, 32'd1);
        next_edge();
        snp_op = 3'd2; snp_addr = 32'h0000_0040;
        monitor_op(0, 20);
        chk("t6_res1_k", res_k, 32'd3);
        chk("t6_busy",   rdy_cnt, 32'd0);
        chk("t6_code1",  {30'd0, res_code_s}, 32'd0);
        @(negedge clk);
        chk("t6_acc2", {31'd0, snp_ready}, 32'd1);
        next_edge();
        snp_valid = 1'b0;
        monitor_op(0, 20);
        chk("t6_res2_k",  res_k, 32'd3);
        chk("t6_code2",   {30'd0, res_code_s}, 32'd2);
        chk("t6_mu2_cnt", mu_cnt, 32'd0);
        next_edge();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
